// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// State enum, register-control bundle and common constants.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RFLUSH,
    RUN,
    MWAIT
  } state_t;

  typedef struct packed {
    logic en;
    logic clr;
  } reg_ctl_t;

  localparam logic [4:0] X0 = 5'd0;

  localparam reg_ctl_t ADV  = '{en: 1'b1, clr: 1'b0};
  localparam reg_ctl_t FLS  = '{en: 1'b1, clr: 1'b1};
  localparam reg_ctl_t HOLD = '{en: 1'b0, clr: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: EX load feeding a register that ID reads.
// Purely combinational; x0 never creates a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rd,
  input  logic       mem_to_reg,
  output logic       load_use
);

  logic hit1;
  logic hit2;

  assign hit1 = rs1_used && (rs1 == rd);
  assign hit2 = rs2_used && (rs2 == rd);

  assign load_use = mem_to_reg && (rd != X0)
                 && (hit1 || hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers and PC.
// Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RST_FLUSH_CYC = 2,
  parameter int MEM_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic        Rs1UsedD,
  input  logic        Rs2UsedD,
  input  logic        JalD,
  input  logic [4:0]  RdE,
  input  logic        MemToRegE,
  input  logic        BranchTakenE,
  input  logic        JalrE,
  input  logic        MemReqM,
  input  logic        MemAckM,
  output logic        PcEnF,
  output logic        EnD,
  output logic        ClrD,
  output logic        EnE,
  output logic        ClrE,
  output logic        EnM,
  output logic        ClrM,
  output logic        EnW,
  output logic        ClrW,
  output logic        MemErr,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int FW = $clog2(RST_FLUSH_CYC + 1);
  localparam logic [WW-1:0] WMAX  = WW'(MEM_TIMEOUT);
  localparam logic [FW-1:0] FLAST = FW'(RST_FLUSH_CYC - 1);

  state_t          state;
  state_t          state_nx;
  logic [FW-1:0]   fcnt;
  logic [WW-1:0]   wcnt;
  reg_ctl_t        cd, ce, cm, cw;
  logic            pc_en;
  logic            lu;
  logic            mem_stall;
  logic            redirect;
  logic            timeout;
  logic            active;

  hazard_detect u_hd (
    .rs1        (Rs1D),
    .rs2        (Rs2D),
    .rs1_used   (Rs1UsedD),
    .rs2_used   (Rs2UsedD),
    .rd         (RdE),
    .mem_to_reg (MemToRegE),
    .load_use   (lu)
  );

  assign mem_stall = MemReqM && !MemAckM;
  assign redirect  = BranchTakenE || JalrE;
  assign active    = (state == RUN) || (state == MWAIT);

  always_comb begin
    state_nx = state;
    timeout  = 1'b0;
    pc_en    = 1'b1;
    cd       = ADV;
    ce       = ADV;
    cm       = ADV;
    cw       = ADV;
    unique case (state)
      RFLUSH: begin
        pc_en = 1'b0;
        cd    = FLS;
        ce    = FLS;
        cm    = FLS;
        cw    = FLS;
        if (fcnt == FLAST) state_nx = RUN;
      end
      RUN, MWAIT: begin
        // A timeout is treated exactly like an ack.
        if (state == MWAIT && !MemAckM && wcnt == WMAX) timeout = 1'b1;
        if (mem_stall && !timeout) begin
          pc_en    = 1'b0;
          cd       = HOLD;
          ce       = HOLD;
          cm       = HOLD;
          cw       = FLS;
          state_nx = MWAIT;
        end else begin
          state_nx = RUN;
          if (redirect) begin
            cd = FLS;
            ce = FLS;
          end else if (lu) begin
            pc_en = 1'b0;
            cd    = HOLD;
            ce    = FLS;
          end else if (JalD) begin
            cd = FLS;
          end
        end
      end
      default: begin
        pc_en    = 1'b0;
        cd       = FLS;
        ce       = FLS;
        cm       = FLS;
        cw       = FLS;
        state_nx = RFLUSH;
      end
    endcase
    if (rst) begin
      pc_en = 1'b0;
      cd    = FLS;
      ce    = FLS;
      cm    = FLS;
      cw    = FLS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RFLUSH;
      fcnt   <= '0;
      wcnt   <= '0;
      MemErr <= 1'b0;
    end else begin
      state <= state_nx;
      fcnt  <= (state == RFLUSH) ? fcnt + 1'b1 : '0;
      if (state == RUN) wcnt <= WW'(1);
      else if (state == MWAIT) wcnt <= wcnt + 1'b1;
      if (timeout) MemErr <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else if (active) begin
      if (!pc_en) StallCnt <= StallCnt + 32'd1;
      if (cd.clr || ce.clr || cw.clr) FlushCnt <= FlushCnt + 32'd1;
    end
  end
`else
  assign StallCnt = 32'd0;
  assign FlushCnt = 32'd0;
  logic unused_active;
  assign unused_active = active;
`endif

  assign PcEnF = pc_en;
  assign EnD   = cd.en;
  assign ClrD  = cd.clr;
  assign EnE   = ce.en;
  assign ClrE  = ce.clr;
  assign EnM   = cm.en;
  assign ClrM  = cm.clr;
  assign EnW   = cw.en;
  assign ClrW  = cw.clr;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (RST_FLUSH_CYC=2, MEM_TIMEOUT=4).
// Control vector: {PcEnF,EnD,ClrD,EnE,ClrE,EnM,ClrM,EnW,ClrW}.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, RdE;
  logic        Rs1UsedD, Rs2UsedD, JalD;
  logic        MemToRegE, BranchTakenE, JalrE;
  logic        MemReqM, MemAckM;
  logic        PcEnF, EnD, ClrD, EnE, ClrE;
  logic        EnM, ClrM, EnW, ClrW, MemErr;
  logic [31:0] StallCnt, FlushCnt;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] FLUSH = 9'b0_11_11_11_11;
  localparam logic [8:0] RUNV  = 9'b1_10_10_10_10;
  localparam logic [8:0] STALL = 9'b0_00_00_00_11;
  localparam logic [8:0] REDIR = 9'b1_11_11_10_10;
  localparam logic [8:0] LUV   = 9'b0_00_11_10_10;
  localparam logic [8:0] JALV  = 9'b1_11_10_10_10;

  pipe_hazard_ctrl #(
    .RST_FLUSH_CYC (2),
    .MEM_TIMEOUT   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1UsedD     (Rs1UsedD),
    .Rs2UsedD     (Rs2UsedD),
    .JalD         (JalD),
    .RdE          (RdE),
    .MemToRegE    (MemToRegE),
    .BranchTakenE (BranchTakenE),
    .JalrE        (JalrE),
    .MemReqM      (MemReqM),
    .MemAckM      (MemAckM),
    .PcEnF        (PcEnF),
    .EnD          (EnD),
    .ClrD         (ClrD),
    .EnE          (EnE),
    .ClrE         (ClrE),
    .EnM          (EnM),
    .ClrM         (ClrM),
    .EnW          (EnW),
    .ClrW         (ClrW),
    .MemErr       (MemErr),
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctl();
    return {PcEnF, EnD, ClrD, EnE, ClrE, EnM, ClrM, EnW, ClrW};
  endfunction

  task automatic idle();
    Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0;
    Rs1UsedD = 1'b0; Rs2UsedD = 1'b0; JalD = 1'b0;
    MemToRegE = 1'b0; BranchTakenE = 1'b0; JalrE = 1'b0;
    MemReqM = 1'b0; MemAckM = 1'b0;
  endtask

  // Check combinational controls for the current inputs, then advance one clock.
  task automatic cyc(input string tag, input logic [8:0] exp);
    #1;
    check(tag, 32'(ctl()), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", 32'(ctl()), 32'(FLUSH));
    check("rst_err", 32'(MemErr), 32'd0);
    check("rst_scnt", StallCnt, 32'd0);
    check("rst_fcnt", FlushCnt, 32'd0);
    rst = 1'b0;
    cyc("rflush1", FLUSH);
    cyc("rflush2", FLUSH);
    cyc("run", RUNV);

    MemToRegE = 1'b1; RdE = 5'd5; Rs2D = 5'd5; Rs2UsedD = 1'b1;
    cyc("lu_rs2", LUV);
    MemToRegE = 1'b0;
    cyc("lu_after", RUNV);
    MemToRegE = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
    cyc("lu_x0", RUNV);
    Rs2UsedD = 1'b0; Rs1D = 5'd7; Rs1UsedD = 1'b1; RdE = 5'd7;
    cyc("lu_rs1", LUV);
    Rs1UsedD = 1'b0;
    cyc("lu_unused", RUNV);
    Rs1UsedD = 1'b1; JalD = 1'b1;
    cyc("lu_jal", LUV);
    MemToRegE = 1'b0;
    cyc("jal", JALV);
    JalD = 1'b0; BranchTakenE = 1'b1;
    cyc("branch", REDIR);
    BranchTakenE = 1'b0; JalrE = 1'b1;
    cyc("jalr", REDIR);
    JalrE = 1'b0; BranchTakenE = 1'b1; MemToRegE = 1'b1;
    cyc("br_lu", REDIR);
    idle();
    cyc("clear", RUNV);

    MemReqM = 1'b1;
    for (int i = 0; i < 3; i++) cyc("mwait", STALL);
    MemAckM = 1'b1;
    cyc("mack", RUNV);
    idle();
    MemReqM = 1'b1; BranchTakenE = 1'b1;
    for (int i = 0; i < 3; i++) cyc("mwait_br", STALL);
    MemAckM = 1'b1;
    cyc("mack_br", REDIR);
    idle();
    MemReqM = 1'b1; MemAckM = 1'b1;
    cyc("ack1", RUNV);
    idle();

`ifdef HAZARD_PERF_CNT_EN
    check("scnt", StallCnt, 32'd9);
    check("fcnt", FlushCnt, 32'd14);
`else
    check("scnt", StallCnt, 32'd0);
    check("fcnt", FlushCnt, 32'd0);
`endif

    MemReqM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("to_noerr", 32'(MemErr), 32'd0);
      cyc("to_wait", STALL);
    end
    cyc("to_adv", RUNV);
    idle();
    check("to_err", 32'(MemErr), 32'd1);
    cyc("to_run", RUNV);
    cyc("to_run2", RUNV);
    check("to_sticky", 32'(MemErr), 32'd1);

    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_err", 32'(MemErr), 32'd0);
    check("rst2_ctl", 32'(ctl()), 32'(FLUSH));
    rst = 1'b0;
    cyc("rst2_f1", FLUSH);
    cyc("rst2_f2", FLUSH);
    cyc("rst2_run", RUNV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the en/clear pair of every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Resolves load-use hazards, taken branches and jumps, and multi-cycle data-RAM waits.
- Runs a post-reset bubble sequence and a RAM-wait timeout.

Parameters:
- RST_FLUSH_CYC, 2: cycles of forced bubbles after reset deassertion (≥1).
- MEM_TIMEOUT, 255: maximum wait cycles for the RAM ack before abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- Rs1D  in  5  ID-stage rs1 index
- Rs2D  in  5  ID-stage rs2 index
- Rs1UsedD  in  1  ID instruction reads rs1
- Rs2UsedD  in  1  ID instruction reads rs2
- JalD  in  1  JAL decoded in ID
- RdE  in  5  EX-stage destination
- MemToRegE  in  1  EX instruction is a load
- BranchTakenE  in  1  branch resolved taken in EX
- JalrE  in  1  JALR in EX
- MemReqM  in  1  MEM-stage load/store active
- MemAckM  in  1  RAM completes access this cycle
- PcEnF  out  1  PC update enable
- EnD, ClrD  out  1 each  IF/ID register enable and clear
- EnE, ClrE  out  1 each  ID/EX register enable and clear
- EnM, ClrM  out  1 each  EX/MEM register enable and clear
- EnW, ClrW  out  1 each  MEM/WB register enable and clear
- MemErr  out  1  sticky RAM-timeout flag
- StallCnt  out  32  stall-cycle count (optional feature)
- FlushCnt  out  32  flush-event count (optional feature)

Behaviour:
Register semantics
- A register clears only when En=1 and Clr=1.
- En=0 means hold.

Reset and state machine
- Reset values: PcEnF=0, all En=1, all Clr=1, MemErr=0, counters=0.
- FSM states: RFLUSH, RUN, MWAIT. Reset enters RFLUSH.
- Wait counter width is clog2(MEM_TIMEOUT+1).

RFLUSH
- For RST_FLUSH_CYC cycles after rst falls: PcEnF=0, all En=1, all Clr=1.
- Then go to RUN.
- rst asserted in any state returns to RFLUSH next edge and restarts the count.

RUN (outputs combinational from inputs and state), priority high to low:
1. Memory stall: MemReqM && !MemAckM.
   - PcEnF=EnD=EnE=EnM=0.
   - EnW=1, ClrW=1 (bubble into WB; prevents duplicate write).
   - Next state MWAIT, wait counter=1.
2. Redirect: BranchTakenE || JalrE.
   - PcEnF=1.
   - EnD=1, ClrD=1; EnE=1, ClrE=1.
   - EnM/EnW=1, no clear.
3. Load-use: MemToRegE && RdE!=0 && ((Rs1UsedD && Rs1D==RdE) || (Rs2UsedD && Rs2D==RdE)).
   - PcEnF=0, EnD=0.
   - EnE=1, ClrE=1.
   - Others advance.
4. JalD (and no load-use): EnD=1, ClrD=1; others advance.
5. Default: all En=1, all Clr=0, PcEnF=1.

MWAIT
- Same outputs as the memory stall in RUN.
- Wait counter increments each cycle.
- MemAckM=1: outputs as RUN default (whole pipe advances, EX-stage redirect/load-use rules applied normally); next state RUN.
- Counter reaches MEM_TIMEOUT without ack: MemErr<=1 (sticky until rst); treat as ack this cycle; next state RUN.

Boundary and simultaneous events
- Single-cycle ack (MemReqM and MemAckM in the same cycle): zero stall.
- MemReqM must stay asserted during MWAIT. This is guaranteed because the EX/MEM register is frozen.
- Branch/JALR in EX while MEM stalls: redirect is deferred; EX is frozen, so it applies on the ack cycle.
- Redirect and load-use together: impossible from the same EX instruction. Redirect wins by priority.
- Load-use with JalD: stall wins; JAL is flushed after the bubble.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined:
  - StallCnt increments on every cycle with PcEnF=0 in RUN/MWAIT.
  - FlushCnt increments on every cycle any of ClrD/ClrE/ClrW=1 in RUN/MWAIT (not in RFLUSH).
  - Both are 32-bit, wrap at 2^32, and are zero on rst.
- Undefined: StallCnt and FlushCnt tied to 0; no counter flops.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state enum (RFLUSH, RUN, MWAIT).
  - Register-control struct {en, clr}.
  - Constant X0=5'd0.
- One sub-module, hazard_detect: purely combinational load-use comparator.
- FSM, counters and priority mux remain in the top module.

Test Plan:
- Reset with RST_FLUSH_CYC=2: rst 1→0 → 2 cycles of PcEnF=0 and all Clr=1, then third cycle all En=1, Clr=0, PcEnF=1.
- Load-use: MemToRegE=1, RdE=5, Rs2D=5, Rs2UsedD=1 → one cycle PcEnF=0, EnD=0, EnE=1, ClrE=1. RdE=0 with the same rs → no stall.
- Redirect: BranchTakenE=1 → ClrD=ClrE=1 with EnD=EnE=1 for one cycle. JalD alone → only ClrD=1.
- RAM wait: MemReqM=1, MemAckM=0 for 3 cycles, then 1 → 3 cycles of EnM=0 and ClrW=1, 4th cycle all advance. BranchTakenE held during the wait → flush occurs on the ack cycle only.
- Timeout with MEM_TIMEOUT=4: no ack → MemErr rises after the 4th wait cycle and the pipe advances. MemErr stays 1 until rst.
- Perf counters (HAZARD_PERF_CNT_EN defined): load-use plus 3-cycle RAM wait → StallCnt=4; FlushCnt counts redirect cycles. Macro undefined → both read 0.
